// File: rtl/afifo_multich_if.sv
// Handshake/data bundle for afifo_multich: write-side and read-side signals.
// The master modport is the producer/consumer side, the slave modport is the FIFO.
interface afifo_multich_if #(
  parameter int DATA_WIDTH    = 24,
  parameter int CHANNELS      = 2,
  parameter int ADDRESS_WIDTH = 4
);
  localparam int W  = DATA_WIDTH * CHANNELS;
  localparam int PW = ADDRESS_WIDTH + 1;

  // Write domain (WClk)
  logic [W-1:0]  Data_in;
  logic          WriteEn_in;
  logic          Full_out;
  logic          AlmostFull_out;
  logic [PW-1:0] WrLevel_out;
  logic          Overflow_out;

  // Read domain (RClk)
  logic          ReadEn_in;
  logic [W-1:0]  Data_out;
  logic          Empty_out;
  logic          AlmostEmpty_out;
  logic [PW-1:0] RdLevel_out;
  logic          Underflow_out;

  modport master (
    output Data_in, WriteEn_in, ReadEn_in,
    input  Full_out, AlmostFull_out, WrLevel_out, Overflow_out,
    input  Data_out, Empty_out, AlmostEmpty_out, RdLevel_out, Underflow_out
  );

  modport slave (
    input  Data_in, WriteEn_in, ReadEn_in,
    output Full_out, AlmostFull_out, WrLevel_out, Overflow_out,
    output Data_out, Empty_out, AlmostEmpty_out, RdLevel_out, Underflow_out
  );
endinterface

// File: rtl/afifo_multich.sv
// afifo_multich: dual-clock multi-channel sample FIFO (WClk -> RClk) with
// binary/Gray pointers, SYNC_STAGES-deep synchronisers, fill levels,
// almost-full/almost-empty flags and sticky overflow/underflow flags.
// Optional macro AFIFO_FWFT_EN selects first-word fall-through read mode
// (one-entry output register; RdLevel_out counts the held word).
module afifo_multich #(
  parameter int DATA_WIDTH      = 24,
  parameter int CHANNELS        = 2,
  parameter int ADDRESS_WIDTH   = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int ALMOST_FULL_TH  = (1 << ADDRESS_WIDTH) - 2,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic           RClk,
  input  logic           PresetFull,
  input  logic           WClk,
  afifo_multich_if.slave bus
);
  localparam int AW    = ADDRESS_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam int PW    = AW + 1;
  localparam int W     = DATA_WIDTH * CHANNELS;

  typedef logic [PW-1:0] ptr_t;

  localparam ptr_t AF_TH = ptr_t'(ALMOST_FULL_TH);
  localparam ptr_t AE_TH = ptr_t'(ALMOST_EMPTY_TH);

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // ---------------------------------------------------------------------------
  // Reset synchronisers: assert immediately, release after SYNC_STAGES edges
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] w_rst_pipe, r_rst_pipe;
  logic                   w_rst, r_rst;

  // Write-domain reset release pipeline
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge WClk or posedge PresetFull) begin
    if (PresetFull) w_rst_pipe <= '1;
    else            w_rst_pipe <= {w_rst_pipe[SYNC_STAGES-2:0], 1'b0};
  end

  // Read-domain reset release pipeline
  always_ff @(posedge RClk or posedge PresetFull) begin
    if (PresetFull) r_rst_pipe <= '1;
    else            r_rst_pipe <= {r_rst_pipe[SYNC_STAGES-2:0], 1'b0};
  end

  assign w_rst = w_rst_pipe[SYNC_STAGES-1];
  assign r_rst = r_rst_pipe[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [W-1:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Write domain
  // ---------------------------------------------------------------------------
  ptr_t                            wbin, wgray, rgray_sync;
  logic [SYNC_STAGES-1:0][PW-1:0]  rgray_pipe;
  logic                            full_q, afull_q, overflow_q;
  ptr_t                            wr_level_q;
  logic                            w_accept, full_next;
  ptr_t                            wbin_next, wgray_next, wr_level_next;

  // Bring the read-side Gray pointer into WClk
  always_ff @(posedge WClk or posedge w_rst) begin
    if (w_rst) rgray_pipe <= '0;
    else       rgray_pipe <= {rgray_pipe[SYNC_STAGES-2:0], wgray_dummy_guard(rgray)};
  end

  assign rgray_sync = rgray_pipe[SYNC_STAGES-1];

  // Write acceptance, next pointer, full compare and occupancy estimate
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    w_accept      = bus.WriteEn_in & ~full_q;
    wbin_next     = wbin + ptr_t'(w_accept);
    wgray_next    = bin2gray(wbin_next);
    full_next     = (wgray_next == {~rgray_sync[AW:AW-1], rgray_sync[AW-2:0]});
    wr_level_next = wbin_next - gray2bin(rgray_sync);
  end

  // Write pointers and write-side status registers
  always_ff @(posedge WClk or posedge w_rst) begin
    if (w_rst) begin
      wbin       <= '0;
      wgray      <= '0;
      full_q     <= 1'b1;
      afull_q    <= 1'b1;
      wr_level_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wbin       <= wbin_next;
      wgray      <= wgray_next;
      full_q     <= full_next;
      afull_q    <= (wr_level_next >= AF_TH);
      wr_level_q <= wr_level_next;
      overflow_q <= overflow_q | (bus.WriteEn_in & full_q);
    end
  end

  // Entry write into the storage array
  // NOTE: the array has no reset; contents are only observable after a write.
  always_ff @(posedge WClk) begin
    if (w_accept) mem[wbin[AW-1:0]] <= bus.Data_in;
  end

  // ---------------------------------------------------------------------------
  // Read domain
  // ---------------------------------------------------------------------------
  ptr_t                            rbin, rgray, wgray_sync;
  logic [SYNC_STAGES-1:0][PW-1:0]  wgray_pipe;
  logic                            mem_empty_q, aempty_q, underflow_q, r_empty;
  ptr_t                            rd_level_q;
  logic [W-1:0]                    data_q;
  logic                            r_take, mem_empty_next;
  ptr_t                            rbin_next, rcons_next, rd_level_next;
`ifdef AFIFO_FWFT_EN
  logic                            ovalid_q, ovalid_next, r_pop;
`endif

  // Bring the write-side Gray pointer into RClk
  always_ff @(posedge RClk or posedge r_rst) begin
    if (r_rst) wgray_pipe <= '0;
    else       wgray_pipe <= {wgray_pipe[SYNC_STAGES-2:0], wgray};
  end

  assign wgray_sync = wgray_pipe[SYNC_STAGES-1];

  // Memory-side read, consumed-entry pointer and occupancy estimate.
  // rbin advances when a word leaves the array; rcons (what the writer sees)
  // advances only when the word leaves the FIFO, so a word parked in the
  // fall-through register still holds its slot.
  always_comb begin
`ifdef AFIFO_FWFT_EN
    r_pop       = bus.ReadEn_in & ovalid_q;
    r_take      = ~mem_empty_q & (~ovalid_q | r_pop);
    ovalid_next = r_take | (ovalid_q & ~r_pop);
    rbin_next   = rbin + ptr_t'(r_take);
    rcons_next  = rbin_next - ptr_t'(ovalid_next);
`else
    r_take      = bus.ReadEn_in & ~mem_empty_q;
    rbin_next   = rbin + ptr_t'(r_take);
    rcons_next  = rbin_next;
`endif
    mem_empty_next = (bin2gray(rbin_next) == wgray_sync);
    rd_level_next  = gray2bin(wgray_sync) - rcons_next;
  end

`ifdef AFIFO_FWFT_EN
  assign r_empty = ~ovalid_q;
`else
  assign r_empty = mem_empty_q;
`endif

  // Read pointers, output data and read-side status registers
  always_ff @(posedge RClk or posedge r_rst) begin
    if (r_rst) begin
      rbin        <= '0;
      rgray       <= '0;
      mem_empty_q <= 1'b1;
      aempty_q    <= 1'b1;
      rd_level_q  <= '0;
      underflow_q <= 1'b0;
      data_q      <= '0;
`ifdef AFIFO_FWFT_EN
      ovalid_q    <= 1'b0;
`endif
    end else begin
      rbin        <= rbin_next;
      rgray       <= bin2gray(rcons_next);
      mem_empty_q <= mem_empty_next;
      aempty_q    <= (rd_level_next <= AE_TH);
      rd_level_q  <= rd_level_next;
      underflow_q <= underflow_q | (bus.ReadEn_in & r_empty);
      if (r_take) data_q <= mem[rbin[AW-1:0]];
`ifdef AFIFO_FWFT_EN
      ovalid_q    <= ovalid_next;
`endif
    end
  end

  // Identity helper keeping the synchroniser input a plain Gray register
  function automatic ptr_t wgray_dummy_guard(input ptr_t g);
    return g;
  endfunction

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.Full_out        = full_q;
  assign bus.AlmostFull_out  = afull_q;
  assign bus.WrLevel_out     = wr_level_q;
  assign bus.Overflow_out    = overflow_q;
  assign bus.Data_out        = data_q;
  assign bus.Empty_out       = r_empty;
  assign bus.AlmostEmpty_out = aempty_q;
  assign bus.RdLevel_out     = rd_level_q;
  assign bus.Underflow_out   = underflow_q;

endmodule

// File: tb/tb_afifo_multich.sv
// Bench for afifo_multich: table-driven fill/drain vectors, hand-written
// reset/overflow/underflow/single-entry sequences, and a scoreboard-checked
// random stream under both clock ratios. Works with or without AFIFO_FWFT_EN.
module tb_afifo_multich;
  localparam int DW    = 24;
  localparam int CH    = 2;
  localparam int AW    = 4;
  localparam int SS    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int W     = DW * CH;
  localparam int N     = 1000;

  logic RClk = 1'b0;
  logic WClk = 1'b0;
  logic PresetFull = 1'b0;
  int   w_half = 52;   // WClk ~48 MHz vs RClk 100 MHz (ratio 2.08)
  int   r_half = 25;

  always #(w_half) WClk = ~WClk;
  always #(r_half) RClk = ~RClk;

  afifo_multich_if #(.DATA_WIDTH(DW), .CHANNELS(CH), .ADDRESS_WIDTH(AW)) bus ();

  afifo_multich #(
    .DATA_WIDTH(DW), .CHANNELS(CH), .ADDRESS_WIDTH(AW), .SYNC_STAGES(SS),
    .ALMOST_FULL_TH(DEPTH - 2), .ALMOST_EMPTY_TH(2)
  ) dut (
    .RClk      (RClk),
    .PresetFull(PresetFull),
    .WClk      (WClk),
    .bus       (bus)
  );

  int checks = 0;
  int failures = 0;
  logic [W-1:0] sb [$];

  typedef struct { int writes; logic full; logic afull; int level; } wr_vec_t;
  typedef struct { int reads; logic empty; logic aempty; int level; } rd_vec_t;
  wr_vec_t wv [6];
  rd_vec_t rv [6];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Entry i carries L = i on channel 0 and R = ~i on channel 1
  function automatic logic [W-1:0] word(input int i);
    logic [DW-1:0] l;
    l = DW'(i);
    return {~l, l};
  endfunction

  // Caller sits just after a WClk edge; one write attempt on the next edge
  task automatic write_word(input logic [W-1:0] d);
    bus.Data_in    = d;
    bus.WriteEn_in = 1'b1;
    if (!bus.Full_out) sb.push_back(d);
    @(posedge WClk); #1;
    bus.WriteEn_in = 1'b0;
  endtask

  // Caller sits just after an RClk edge; one read/pop on the next edge
  task automatic read_one(input string name);
`ifdef AFIFO_FWFT_EN
    if (!bus.Empty_out) begin
      if (sb.size() == 0) fail_now({name, "_sb_empty"});
      else check(name, bus.Data_out, sb.pop_front());
    end
    bus.ReadEn_in = 1'b1;
    @(posedge RClk); #1;
    bus.ReadEn_in = 1'b0;
`else
    logic take;
    take = !bus.Empty_out;
    bus.ReadEn_in = 1'b1;
    @(posedge RClk); #1;
    bus.ReadEn_in = 1'b0;
    if (take) begin
      if (sb.size() == 0) fail_now({name, "_sb_empty"});
      else check(name, bus.Data_out, sb.pop_front());
    end
`endif
  endtask

  task automatic check_reset_state(input string p);
    check({p, "_full"},   W'(bus.Full_out),        W'(1));
    check({p, "_afull"},  W'(bus.AlmostFull_out),  W'(1));
    check({p, "_empty"},  W'(bus.Empty_out),       W'(1));
    check({p, "_aempty"}, W'(bus.AlmostEmpty_out), W'(1));
    check({p, "_wrlvl"},  W'(bus.WrLevel_out),     W'(0));
    check({p, "_rdlvl"},  W'(bus.RdLevel_out),     W'(0));
    check({p, "_ovf"},    W'(bus.Overflow_out),    W'(0));
    check({p, "_unf"},    W'(bus.Underflow_out),   W'(0));
    check({p, "_dout"},   bus.Data_out,            W'(0));
  endtask

  // Count WClk edges until Full_out falls after reset release
  task automatic wait_full_drop(input string p);
    int n;
    n = 0;
    while (bus.Full_out && n < 10) begin
      @(posedge WClk); #1;
      n++;
    end
    check({p, "_full_dropped"}, W'(bus.Full_out), W'(0));
    check({p, "_full_drop_edges_le_ss1"}, W'(n <= SS + 1), W'(1));
  endtask

  task automatic run_stream(input int base, input string p);
    int lvl_bad;
    lvl_bad = 0;
    fork
      begin : writer
        int sent, cyc;
        sent = 0;
        cyc  = 0;
        @(posedge WClk); #1;
        while (sent < N && cyc < 40000) begin
          if (!bus.Full_out && $urandom_range(0, 1) == 1) begin
            bus.Data_in    = word(base + sent);
            bus.WriteEn_in = 1'b1;
            sb.push_back(bus.Data_in);
            sent++;
          end else begin
            bus.WriteEn_in = 1'b0;
          end
          @(posedge WClk); #1;
          cyc++;
          if (bus.WrLevel_out > DEPTH) lvl_bad++;
        end
        bus.WriteEn_in = 1'b0;
        check({p, "_sent"}, W'(sent), W'(N));
      end
      begin : reader
        int got, cyc;
        logic pend;
        got  = 0;
        cyc  = 0;
        pend = 1'b0;
        @(posedge RClk); #1;
        while (got < N && cyc < 80000) begin
`ifdef AFIFO_FWFT_EN
          if (!bus.Empty_out && $urandom_range(0, 1) == 1) begin
            if (sb.size() == 0) fail_now({p, "_sb_empty"});
            else check({p, "_data"}, bus.Data_out, sb.pop_front());
            got++;
            bus.ReadEn_in = 1'b1;
          end else begin
            bus.ReadEn_in = 1'b0;
          end
`else
          if (pend) begin
            if (sb.size() == 0) fail_now({p, "_sb_empty"});
            else check({p, "_data"}, bus.Data_out, sb.pop_front());
            got++;
          end
          pend = (got < N) && !bus.Empty_out && ($urandom_range(0, 1) == 1);
          bus.ReadEn_in = pend;
`endif
          @(posedge RClk); #1;
          cyc++;
          if (bus.RdLevel_out > DEPTH) lvl_bad++;
        end
        bus.ReadEn_in = 1'b0;
        check({p, "_recv"}, W'(got), W'(N));
      end
    join
    check({p, "_level_bound_violations"}, W'(lvl_bad), W'(0));
    check({p, "_sb_drained"}, W'(sb.size()), W'(0));
    check({p, "_no_overflow"}, W'(bus.Overflow_out), W'(0));
    check({p, "_no_underflow"}, W'(bus.Underflow_out), W'(0));
  endtask

  int done;
  int n;
  logic [W-1:0] last_word;
  logic [W-1:0] single;

  initial begin
    wv[0] = '{1,  1'b0, 1'b0, 1};
    wv[1] = '{2,  1'b0, 1'b0, 2};
    wv[2] = '{13, 1'b0, 1'b0, 13};
    wv[3] = '{14, 1'b0, 1'b1, 14};
    wv[4] = '{15, 1'b0, 1'b1, 15};
    wv[5] = '{16, 1'b1, 1'b1, 16};
    rv[0] = '{0,  1'b0, 1'b0, 16};
    rv[1] = '{1,  1'b0, 1'b0, 15};
    rv[2] = '{13, 1'b0, 1'b0, 3};
    rv[3] = '{14, 1'b0, 1'b1, 2};
    rv[4] = '{15, 1'b0, 1'b1, 1};
    rv[5] = '{16, 1'b1, 1'b1, 0};

    bus.Data_in    = '0;
    bus.WriteEn_in = 1'b0;
    bus.ReadEn_in  = 1'b0;

    // Power-on reset
    #2 PresetFull = 1'b1;
    repeat (3) @(posedge RClk);
    #1;
    check_reset_state("init");
    PresetFull = 1'b0;
    @(posedge WClk); #1;
    wait_full_drop("init");

    // Fill: level, almost-full and full after each tabled write count
    done = 0;
    for (int v = 0; v < 6; v++) begin
      while (done < wv[v].writes) begin
        write_word(word(done));
        done++;
      end
      check($sformatf("fill%0d_full", wv[v].writes),  W'(bus.Full_out),       W'(wv[v].full));
      check($sformatf("fill%0d_afull", wv[v].writes), W'(bus.AlmostFull_out), W'(wv[v].afull));
      check($sformatf("fill%0d_level", wv[v].writes), W'(bus.WrLevel_out),    W'(wv[v].level));
    end

    // Extra write while full: rejected, sticky overflow
    write_word(48'h0000_0000_DEAD);
    check("ovf_flag",  W'(bus.Overflow_out), W'(1));
    check("ovf_full",  W'(bus.Full_out),     W'(1));
    check("ovf_level", W'(bus.WrLevel_out),  W'(16));
    repeat (2) @(posedge WClk); #1;
    check("ovf_sticky", W'(bus.Overflow_out), W'(1));

    // Drain: entries 0..15 in order, read-side status per tabled count
    repeat (SS + 4) @(posedge RClk);
    #1;
    done = 0;
    for (int v = 0; v < 6; v++) begin
      while (done < rv[v].reads) begin
        read_one("drain_data");
        done++;
      end
      check($sformatf("drain%0d_empty", rv[v].reads),  W'(bus.Empty_out),       W'(rv[v].empty));
      check($sformatf("drain%0d_aempty", rv[v].reads), W'(bus.AlmostEmpty_out), W'(rv[v].aempty));
      check($sformatf("drain%0d_level", rv[v].reads),  W'(bus.RdLevel_out),     W'(rv[v].level));
    end
    check("drain_sb_empty", W'(sb.size()), W'(0));

    // Read while empty: sticky underflow, output holds entry 15
    bus.ReadEn_in = 1'b1;
    repeat (3) @(posedge RClk);
    #1;
    bus.ReadEn_in = 1'b0;
    check("unf_flag",  W'(bus.Underflow_out), W'(1));
    check("unf_hold",  bus.Data_out,          word(15));
    check("unf_level", W'(bus.RdLevel_out),   W'(0));
    check("unf_empty", W'(bus.Empty_out),     W'(1));

    // Reset in the middle of write traffic
    @(posedge WClk); #1;
    bus.Data_in    = word(100);
    bus.WriteEn_in = 1'b1;
    repeat (3) @(posedge WClk);
    @(posedge RClk); #1;
    PresetFull = 1'b1;
    repeat (3) @(posedge RClk);
    #1;
    check_reset_state("midrst");
    bus.WriteEn_in = 1'b0;
    PresetFull = 1'b0;
    sb.delete();
    @(posedge WClk); #1;
    wait_full_drop("midrst");
    repeat (SS + 4) @(posedge RClk);
    #1;
    check("midrst_empty_after", W'(bus.Empty_out),   W'(1));
    check("midrst_rdlvl_after", W'(bus.RdLevel_out), W'(0));

    // Random streaming, slow writer then slow reader
    run_stream(1000, "stream_w_slow");
    w_half = 25;
    r_half = 52;
    run_stream(3000, "stream_r_slow");
    last_word = word(3000 + N - 1);

    // Single entry {R=0x123456, L=0xABCDEF}
    single = {24'h123456, 24'hABCDEF};
    @(posedge WClk); #1;
    write_word(single);
    @(posedge RClk); #1;
    n = 0;
    while (bus.Empty_out && n < 20) begin
      @(posedge RClk); #1;
      n++;
    end
    check("single_not_empty", W'(bus.Empty_out), W'(0));
`ifdef AFIFO_FWFT_EN
    check("fwft_head_no_read", bus.Data_out, single);
    read_one("fwft_pop_data");
    check("fwft_empty_after_pop", W'(bus.Empty_out), W'(1));
`else
    check("std_hold_no_read", bus.Data_out, last_word);
    read_one("std_single_data");
    check("std_empty_after_read", W'(bus.Empty_out), W'(1));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit
  initial begin
    #20000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
